// File: rtl/ram_dual_port.sv
// Two-port word RAM over one shared array, with a base-address window, read-valid and range-error pulses.
// Read latency is 1 or 2 cycles. There is no backpressure: a request is accepted every cycle.
module ram_dual_port #(
  parameter int          DATA_WIDTH   = 32,
  parameter int          DEPTH        = 65536,
  parameter int          ADDR_WIDTH   = 32,
  parameter logic [31:0] OFFSET       = 32'h00000000,
  parameter int          READ_LATENCY = 1,
  parameter bit          WRITE_FIRST  = 1'b0
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    a_read,
  input  logic                    a_write,
  input  logic [ADDR_WIDTH-1:0]   a_address,
  input  logic [DATA_WIDTH/8-1:0] a_byteenable,
  input  logic [DATA_WIDTH-1:0]   a_wdata,
  output logic [DATA_WIDTH-1:0]   a_rdata,
  output logic                    a_rvalid,
  output logic                    a_error,
  input  logic                    b_read,
  input  logic                    b_write,
  input  logic [ADDR_WIDTH-1:0]   b_address,
  input  logic [DATA_WIDTH/8-1:0] b_byteenable,
  input  logic [DATA_WIDTH-1:0]   b_wdata,
  output logic [DATA_WIDTH-1:0]   b_rdata,
  output logic                    b_rvalid,
  output logic                    b_error
);

  localparam int NB  = DATA_WIDTH / 8;
  localparam int MAW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_WIDTH-1:0] LP_OFFSET = ADDR_WIDTH'(OFFSET);
  localparam logic [ADDR_WIDTH:0]   LP_DEPTH  = (ADDR_WIDTH + 1)'(DEPTH);

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];

  // Index 0 is port A and index 1 is port B.
  logic [1:0]                 w_rd;
  logic [1:0]                 w_wr;
  logic [1:0]                 w_inr;
  logic [1:0]                 w_we;
  logic [1:0][ADDR_WIDTH-1:0] w_addr;
  logic [1:0][ADDR_WIDTH-1:0] w_idx;
  logic [1:0][MAW-1:0]        w_mi;
  logic [1:0][NB-1:0]         w_be;
  logic [1:0][DATA_WIDTH-1:0] w_wdat;
  logic [1:0][DATA_WIDTH-1:0] w_rdata_o;
  logic [1:0]                 w_rvalid_o;
  logic [1:0]                 w_error_o;

  assign w_rd   = {b_read, a_read};
  assign w_wr   = {b_write, a_write};
  assign w_addr = {b_address, a_address};
  assign w_be   = {b_byteenable, a_byteenable};
  assign w_wdat = {b_wdata, a_wdata};

  // Port B is written after port A, so B wins on lanes that both ports enable at the same index.
  always_ff @(posedge clock) begin
    for (int p = 0; p < 2; p++) begin
      for (int i = 0; i < NB; i++) begin
        if (w_we[p] && w_be[p][i]) begin
          r_mem[w_mi[p]][i*8 +: 8] <= w_wdat[p][i*8 +: 8];
        end
      end
    end
  end

  for (genvar p = 0; p < 2; p++) begin : g_port
    logic [DATA_WIDTH-1:0] w_old;
    logic [DATA_WIDTH-1:0] w_rsel;
    logic                  r_vld1;
    logic                  r_err1;
    logic [DATA_WIDTH-1:0] r_dat1;

    // The subtraction wraps, so the lower-bound compare is needed in addition to the index check.
    assign w_idx[p] = w_addr[p] - LP_OFFSET;
    assign w_inr[p] = (w_addr[p] >= LP_OFFSET) && ({1'b0, w_idx[p]} < LP_DEPTH);
    assign w_mi[p]  = w_idx[p][MAW-1:0];
    assign w_we[p]  = w_wr[p] && w_inr[p] && !reset;
    assign w_old    = r_mem[w_mi[p]];

    // The other port's write never shows up here. Only this port's own write can, and only in write-first mode.
    always_comb begin
      w_rsel = '0;
      if (w_inr[p]) begin
        w_rsel = w_old;
        if (WRITE_FIRST && w_wr[p]) begin
          for (int i = 0; i < NB; i++) begin
            if (w_be[p][i]) begin
              w_rsel[i*8 +: 8] = w_wdat[p][i*8 +: 8];
            end
          end
        end
      end
    end

    always_ff @(posedge clock) begin
      if (reset) begin
        r_vld1 <= 1'b0;
        r_err1 <= 1'b0;
        r_dat1 <= '0;
      end else begin
        r_vld1 <= w_rd[p];
        r_err1 <= (w_rd[p] || w_wr[p]) && !w_inr[p];
        if (w_rd[p]) begin
          r_dat1 <= w_rsel;
        end
      end
    end

    if (READ_LATENCY == 2) begin : g_lat2
      logic                  r_vld2;
      logic                  r_err2;
      logic [DATA_WIDTH-1:0] r_dat2;

      always_ff @(posedge clock) begin
        if (reset) begin
          r_vld2 <= 1'b0;
          r_err2 <= 1'b0;
          r_dat2 <= '0;
        end else begin
          r_vld2 <= r_vld1;
          r_err2 <= r_err1;
          if (r_vld1) begin
            r_dat2 <= r_dat1;
          end
        end
      end

      assign w_rdata_o[p]  = r_dat2;
      assign w_rvalid_o[p] = r_vld2;
      assign w_error_o[p]  = r_err2;
    end else begin : g_lat1
      assign w_rdata_o[p]  = r_dat1;
      assign w_rvalid_o[p] = r_vld1;
      assign w_error_o[p]  = r_err1;
    end
  end

  assign a_rdata  = w_rdata_o[0];
  assign a_rvalid = w_rvalid_o[0];
  assign a_error  = w_error_o[0];
  assign b_rdata  = w_rdata_o[1];
  assign b_rvalid = w_rvalid_o[1];
  assign b_error  = w_error_o[1];

endmodule

// File: doc/ram_dual_port.md
Name: ram_dual_port

Overview:
- Parametrised successor of the single-port word RAM: two independent read/write ports sharing one storage array.
- Generalised data width, depth and read latency; adds a base-address window, a read-valid indication, an out-of-range error flag and a defined same-address collision policy.
- Serves as instruction/data store where fetch and load/store units access memory concurrently.

Parameters:
- DATA_WIDTH, 32, bits per word; must be a multiple of 8.
- DEPTH, 65536, number of words.
- ADDR_WIDTH, 32, width of the address ports; addresses are word indices.
- OFFSET, 32'h00000000, first word address of the window; valid range is OFFSET to OFFSET+DEPTH-1.
- READ_LATENCY, 1, cycles from read request to rvalid; legal values are 1 or 2.
- WRITE_FIRST, 0, same-port read and write: 0 returns old data, 1 returns newly written data.

Ports:
- clock  in  1  single clock; all logic on the rising edge.
- reset  in  1  synchronous, active-high; clears the pipeline and flags, not the memory contents.
- a_read  in  1  port A read request.
- a_write  in  1  port A write request.
- a_address  in  ADDR_WIDTH  port A word address.
- a_byteenable  in  DATA_WIDTH/8  port A byte lane write enables; bit i controls byte i.
- a_wdata  in  DATA_WIDTH  port A write data.
- a_rdata  out  DATA_WIDTH  port A read data.
- a_rvalid  out  1  one-cycle pulse when a_rdata holds a completed read.
- a_error  out  1  one-cycle pulse when a port A request was out of range.
- b_read, b_write, b_address, b_byteenable, b_wdata, b_rdata, b_rvalid, b_error: same as the port A signals, for port B.

Behaviour:
- Reset, sampled at a rising edge, forces to 0 on that edge: all rdata, rvalid and error outputs, and every internal pipeline stage. Memory contents are untouched. Requests presented in a reset cycle are dropped: no write and no rvalid.
- Address decode: index = address - OFFSET, computed in ADDR_WIDTH bits. In range if address >= OFFSET and index < DEPTH; no wrap-around.
- Out-of-range request (read or write):
  - The write is suppressed.
  - A read still produces an rvalid with rdata = 0.
  - error pulses high aligned with that port's rvalid timing. For a write-only request, error pulses READ_LATENCY cycles after the request.
- Write: at the request edge, each byte lane with its byteenable set is updated; other lanes keep their value. A write with byteenable = 0 is a legal no-op, with no error.
- Read, READ_LATENCY = 1: a request at edge N gives rdata and rvalid at edge N, visible in cycle N+1. rvalid drops in the next cycle unless a new read is issued.
- Read, READ_LATENCY = 2: one extra output register; the result is visible in cycle N+2. Back-to-back reads are fully pipelined, one result per cycle.
- rdata holds its last value when rvalid = 0, except after reset, when it is 0.
- Same-port read and write in one cycle:
  - WRITE_FIRST = 0: returns the pre-write word.
  - WRITE_FIRST = 1: returns the merged word (new bytes on enabled lanes, old bytes elsewhere).
- Cross-port, same index, same cycle:
  - Write/write: merged per byte; port B wins on lanes enabled in both ports; each port's own lanes are applied otherwise.
  - Read on one port, write on the other: the reader gets the old word, independent of WRITE_FIRST.
  - Read/read: both return the same word.
- No backpressure: requests are accepted every cycle and rvalid cannot stall.
- Reset mid-pipeline (READ_LATENCY = 2): an in-flight read is discarded and no rvalid is emitted for it.

Test Plan:
- Basic write/read, defaults: write 0xDEADBEEF to a_address 0x10 with byteenable 0xF, then read on port B at 0x10 → b_rvalid one cycle later with b_rdata = 0xDEADBEEF, b_error = 0.
- Byte merge: after the write above, port A writes 0x11223344 at 0x10 with byteenable 0x5, then reads → a_rdata = 0xDE22BE44.
- Collision: same edge, A writes 0xAAAAAAAA with byteenable 0xF and B writes 0xBBBBBBBB with byteenable 0x3 at index 4; a later read → 0xAAAABBBB.
- Same-port read with write to 0x20 (old value 0x0, new 0x12345678, byteenable 0xF):
  - WRITE_FIRST = 0 → rdata 0x0.
  - WRITE_FIRST = 1 → rdata 0x12345678.
- Window and range, OFFSET = 0x1000, DEPTH = 256:
  - Read at 0x0FFF → rvalid = 1, rdata = 0, error = 1.
  - Write at 0x1100 is ignored; the following read at 0x1100 also → error = 1.
  - Read at 0x10FF → error = 0.
- Latency and reset, READ_LATENCY = 2: reads on consecutive cycles at 0, 1, 2 → rvalid in three consecutive cycles, data in order. Asserting reset one cycle after a read → no rvalid for that read, all outputs 0, and memory data still intact on the next read.
